// File: rtl/lcd_write_scheduler.sv
// Round-robin arbiter and LCD_E timing generator sharing one HD44780 write bus between two requesters.
// Optional power-on init sequence (0x38, 0x0C, 0x06, 0x01) enabled by defining LCD_INIT_SEQ_EN.
module lcd_write_scheduler #(
  parameter int SETUP_CYC    = 2,
  parameter int E_PULSE_CYC  = 12,
  parameter int HOLD_CYC     = 2,
  parameter int GAP_CYC      = 2000,
  parameter int LONG_GAP_CYC = 82000,
  parameter int POWERON_CYC  = 750000,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       busy,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_INIT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] LD_PULSE  = CNT_W'(E_PULSE_CYC);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] LD_LONG   = CNT_W'(LONG_GAP_CYC);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last, last_n;
  logic             ack0_n, ack1_n, busy_n, lcd_e_n, rs_n;
  logic [7:0]       data_n;

  // Clear and home commands need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    is_long_cmd = !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

`ifdef LCD_INIT_SEQ_EN
  localparam logic [CNT_W-1:0] LD_POWERON = CNT_W'(POWERON_CYC);
  logic       init_run, init_run_n;
  logic [1:0] init_idx, init_idx_n;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction
`endif

  // Next-state, counter and next-output computation
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    rs_n    = LCD_RS;
    data_n  = LCD_DATA;
`ifdef LCD_INIT_SEQ_EN
    init_run_n = init_run;
    init_idx_n = init_idx;
`endif
    case (state)
      S_IDLE: begin
        if (req0 && (!req1 || last)) begin
          ack0_n  = 1'b1;
          rs_n    = rs0;
          data_n  = data0;
          last_n  = 1'b0;
          state_n = S_SETUP;
          cnt_n   = LD_SETUP;
        end else if (req1) begin
          ack1_n  = 1'b1;
          rs_n    = rs1;
          data_n  = data1;
          last_n  = 1'b1;
          state_n = S_SETUP;
          cnt_n   = LD_SETUP;
        end else begin
          cnt_n = cnt;
        end
      end
      S_SETUP: begin
        if (cnt > ONE) begin
          cnt_n = cnt - ONE;
        end else begin
          state_n = S_PULSE;
          cnt_n   = LD_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt > ONE) begin
          cnt_n = cnt - ONE;
        end else begin
          state_n = S_HOLD;
          cnt_n   = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt > ONE) begin
          cnt_n = cnt - ONE;
        end else begin
          state_n = S_GAP;
          cnt_n   = is_long_cmd(LCD_RS, LCD_DATA) ? LD_LONG : LD_GAP;
        end
      end
      S_GAP: begin
        if (cnt > ONE) begin
          cnt_n = cnt - ONE;
        end else begin
`ifdef LCD_INIT_SEQ_EN
          if (init_run && init_idx != 2'd3) begin
            init_idx_n = init_idx + 2'd1;
            rs_n       = 1'b0;
            data_n     = init_cmd(init_idx + 2'd1);
            state_n    = S_SETUP;
            cnt_n      = LD_SETUP;
          end else begin
            init_run_n = 1'b0;
            state_n    = S_IDLE;
          end
`else
          state_n = S_IDLE;
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      S_INIT: begin
        if (cnt > ONE) begin
          cnt_n = cnt - ONE;
        end else begin
          rs_n    = 1'b0;
          data_n  = init_cmd(2'd0);
          state_n = S_SETUP;
          cnt_n   = LD_SETUP;
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n  = (state_n != S_IDLE);
    lcd_e_n = (state_n == S_PULSE);
  end

  // State, counter and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
`ifdef LCD_INIT_SEQ_EN
      state    <= S_INIT;
      cnt      <= LD_POWERON;
      busy     <= 1'b1;
      init_run <= 1'b1;
      init_idx <= 2'd0;
`else
      state    <= S_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
`endif
      last     <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b0;
      LCD_DATA <= 8'h00;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last     <= last_n;
      ack0     <= ack0_n;
      ack1     <= ack1_n;
      busy     <= busy_n;
      LCD_E    <= lcd_e_n;
      LCD_RS   <= rs_n;
      LCD_RW   <= 1'b0;
      LCD_DATA <= data_n;
`ifdef LCD_INIT_SEQ_EN
      init_run <= init_run_n;
      init_idx <= init_idx_n;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed self-checking bench for lcd_write_scheduler with shortened timing (2/4/2/10/50, power-on 20).
// Define LCD_INIT_SEQ_EN for both files to exercise the init sequence instead of the default tests.
module tb_lcd_write_scheduler;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, busy, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  int checks = 0;
  int errors = 0;
  int rw_bad = 0;

  lcd_write_scheduler #(
    .SETUP_CYC(2), .E_PULSE_CYC(4), .HOLD_CYC(2), .GAP_CYC(10),
    .LONG_GAP_CYC(50), .POWERON_CYC(20), .CNT_W(20)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .busy(busy), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (LCD_RW !== 1'b0) rw_bad++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Steps negedges until the chosen ack is seen; n = cycles waited, -1 on timeout.
  task automatic wait_ack(input int which, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((which == 0 && ack0) || (which == 1 && ack1)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m, g, cnt0, cnt1, ack_t, np;
    int ord[8];
    int tg[8];
    int dd[8];
    int rise_t[8];
    int rise_d[8];
    int rise_rs[8];
    logic prev_e;

    @(negedge clk);
`ifdef LCD_INIT_SEQ_EN
    // Init sequence precedes the first requester grant
    resetn = 1'b0; req0 = 1'b1; rs0 = 1'b1; data0 = 8'h77;
    repeat (2) @(negedge clk);
    check("init_busy_in_reset", busy, 1);
    resetn = 1'b1;
    np = 0; ack_t = -1; prev_e = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (LCD_E && !prev_e && np < 8) begin
        rise_t[np] = c; rise_d[np] = LCD_DATA; rise_rs[np] = LCD_RS; np++;
      end
      if (ack0 && ack_t < 0) ack_t = c;
      prev_e = LCD_E;
    end
    req0 = 1'b0;
    check("init_pulses", np, 5);
    check("init_d0", rise_d[0], 32'h38);
    check("init_d1", rise_d[1], 32'h0C);
    check("init_d2", rise_d[2], 32'h06);
    check("init_d3", rise_d[3], 32'h01);
    for (int i = 0; i < 4; i++) check("init_rs", rise_rs[i], 0);
    check("init_d_user", rise_d[4], 32'h77);
    check("init_ack_after_long_gap", ack_t - rise_t[3], 57);
`else
    // Test 1: reset state and single write timing
    apply_reset();
    resetn = 1'b0;
    @(negedge clk);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_busy", busy, 0);
    check("rst_e", LCD_E, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_data", LCD_DATA, 0);
    resetn = 1'b1;
    @(negedge clk);
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
    wait_ack(0, 5, n);
    check("t1_ack_latency", n, 1);
    req0 = 1'b0;
    check("t1_rs", LCD_RS, 1);
    check("t1_data", LCD_DATA, 32'h41);
    check("t1_busy_a", busy, 1);
    check("t1_e_a", LCD_E, 0);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) check("t1_ack_one_cycle", ack0, 0);
      check("t1_e", LCD_E, (k >= 2 && k <= 5) ? 1 : 0);
      check("t1_busy", busy, (k <= 17) ? 1 : 0);
      if (k == 18) check("t1_data_hold", LCD_DATA, 32'h41);
    end

    // Test 2: both requesters held from reset alternate 0,1,0,1
    resetn = 1'b0;
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h10;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h20;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    g = 0; cnt0 = 0; cnt1 = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if ((ack0 || ack1) && g < 8) begin
        ord[g] = ack1 ? 1 : 0; tg[g] = c; dd[g] = LCD_DATA; g++;
      end
      if (ack0) begin
        cnt0++;
        if (cnt0 == 1) data0 = 8'h11; else req0 = 1'b0;
      end
      if (ack1) begin
        cnt1++;
        if (cnt1 == 1) data1 = 8'h21; else req1 = 1'b0;
      end
    end
    check("t2_grants", g, 4);
    check("t2_first", tg[0], 1);
    check("t2_o0", ord[0], 0);
    check("t2_o1", ord[1], 1);
    check("t2_o2", ord[2], 0);
    check("t2_o3", ord[3], 1);
    for (int i = 1; i < 4; i++) check("t2_spacing", tg[i] - tg[i-1], 19);
    check("t2_d0", dd[0], 32'h10);
    check("t2_d1", dd[1], 32'h20);
    check("t2_d2", dd[2], 32'h11);
    check("t2_d3", dd[3], 32'h21);

    // Test 3: clear command forces the long gap, next normal command uses the short one
    apply_reset();
    req1 = 1'b1; rs1 = 1'b0; data1 = 8'h01;
    wait_ack(1, 5, n);
    check("t3_ack1", n, 1);
    req1 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; rs0 = 1'b0; data0 = 8'h80;
    wait_ack(0, 100, n);
    check("t3_ack0_at_a59", n, 58);
    check("t3_data", LCD_DATA, 32'h80);
    req0 = 1'b0;
    m = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!busy && m < 0) m = k;
    end
    check("t3_short_gap", m, 18);

    // Test 4: reset while LCD_E high aborts; held request served after release
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h55;
    wait_ack(0, 5, n);
    check("t4_ack", n, 1);
    repeat (3) @(negedge clk);
    check("t4_e_high", LCD_E, 1);
    resetn = 1'b0;
    @(negedge clk);
    check("t4_abort_e", LCD_E, 0);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_ack0", ack0, 0);
    check("t4_abort_ack1", ack1, 0);
    @(negedge clk);
    resetn = 1'b1;
    wait_ack(0, 5, n);
    check("t4_reserve", n, 1);
    check("t4_data", LCD_DATA, 32'h55);
    req0 = 1'b0;
    repeat (20) @(negedge clk);

    // Test 6: a one-cycle request while busy is not latched
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h42;
    wait_ack(1, 5, n);
    check("t6_ack1", n, 1);
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    req0 = 1'b1; data0 = 8'h99;
    @(negedge clk);
    req0 = 1'b0;
    cnt0 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ack0) cnt0++;
    end
    check("t6_no_ack0", cnt0, 0);
    check("t6_data_kept", LCD_DATA, 32'h42);
`endif
    check("rw_zero", rw_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
